// File: rtl/csa_pkg.sv
// Shared definitions for the byte-serial wide-add family.
package csa_pkg;

  // Operation sequencing states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one adder slice; matches the 8-bit carry-skip adder.
  localparam int SLICE_W = 8;

  // Two's-complement overflow: operands share a sign and the sum sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/csa_serial_adder_cskip.sv
// 8-bit carry-skip adder: two 4-bit ripple blocks with a skip path that
// forwards the block carry-in when every bit of the block propagates.
module top (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Ripple inside each block, bypass the block when it fully propagates.
  always_comb begin
    logic [7:0] p;
    logic [7:0] g;
    logic       c;
    logic       blk_cin;
    sum     = '0;
    cout    = 1'b0;
    p       = a ^ b;
    g       = a & b;
    c       = cin;
    blk_cin = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
      if ((i % 4) == 3) begin
        c       = (&p[i -: 4]) ? blk_cin : c;
        blk_cin = c;
      end
    end
    cout = c;
  end

endmodule

// File: rtl/csa_serial_adder.sv
// Byte-serial wide adder: walks the operand pair one byte per cycle through
// a single 8-bit carry-skip adder, carrying between slices in a register.
module csa_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NBYTES = WIDTH / SLICE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 16) begin : g_bad_width
    $fatal(1, "csa_serial_adder: WIDTH must be a multiple of 8 and >= 16");
  end

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Select the current byte of each latched operand for the slice adder.
  always_comb begin
    slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b = b_q[idx_q*SLICE_W +: SLICE_W];
  end

  top u_cskip (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Handshake FSM plus slice datapath; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q                         <= slice_cout;
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  // Derived from registers that are frozen throughout DONE.
  assign out_ovf   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_q[WIDTH-1]);

endmodule

// File: tb/tb_csa_serial_adder.sv
// Self-checking bench for csa_serial_adder (WIDTH=32).
module tb_csa_serial_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  csa_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: full-precision integer arithmetic, packed as {ovf, cout, sum}.
  function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint unsigned u;
    longint          s;
    logic            ovf;
    u   = longint'(a) + longint'(b) + longint'(c);
    s   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ovf, u[32], u[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for one edge, then scramble the inputs.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'($urandom);
  endtask

  // Wait for out_valid and check its latency from the accept edge.
  task automatic wait_done(input string tag);
    int unsigned lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic chk_result(input string tag, input logic [33:0] e);
    chk({tag, "_sum"},  64'(out_sum),  64'(e[31:0]));
    chk({tag, "_cout"}, 64'(out_cout), 64'(e[32]));
    chk({tag, "_ovf"},  64'(out_ovf),  64'(e[33]));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic [33:0]     e;
    logic [W-1:0]    q_a[$];
    logic [W-1:0]    q_b[$];
    logic            q_c[$];
    logic [W-1:0]    ra;
    logic [W-1:0]    rb;
    logic            rc;
    int unsigned     n_in;
    int unsigned     n_out;
    int unsigned     cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sum",       64'(out_sum),   64'd0);
    chk("rst_cout",      64'(out_cout),  64'd0);
    chk("rst_ovf",       64'(out_ovf),   64'd0);
    rst_n = 1'b1;
    step();

    // Carry ripples through every byte.
    accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("busy_run", 64'(busy), 64'd1);
    wait_done("t1");
    chk_result("t1", {1'b0, 1'b1, 32'h0000_0000});
    consume("t1");

    // Positive overflow.
    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("t2");
    chk_result("t2", {1'b1, 1'b0, 32'h8000_0000});
    consume("t2");

    // Negative overflow with carry out.
    accept(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("t3");
    chk_result("t3", {1'b1, 1'b1, 32'h0000_0000});
    consume("t3");

    // Backpressure: outputs hold, a new offer is refused.
    accept(32'h1234_5678, 32'h0000_FFFF, 1'b0);
    wait_done("t4");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = $urandom; in_b = $urandom;
      chk("t4_hold_ready", 64'(in_ready), 64'd0);
      chk_result("t4_hold", {1'b0, 1'b0, 32'h1235_5677});
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      step();
    end
    in_valid = 1'b0;
    chk_result("t4_final", {1'b0, 1'b0, 32'h1235_5677});
    consume("t4");
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // Reset during RUN discards the operation.
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_ready", 64'(in_ready),  64'd1);
    chk("t5_rst_busy",  64'(busy),      64'd0);
    chk("t5_rst_cout",  64'(out_cout),  64'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("t5_post_ready", 64'(in_ready), 64'd1);
    accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done("t5");
    chk_result("t5", {1'b0, 1'b0, 32'h0000_0100});
    consume("t5");

    // Random traffic against a scoreboard.
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 200 && cyc < 8000) begin
      in_valid  = (n_in < 200) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       begin ra = 32'hFFFF_FFFF; rb = $urandom; end
        1:       begin ra = 32'h7FFF_FFFF; rb = 32'(($urandom_range(0, 2))); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      rc        = 1'($urandom);
      in_a      = ra; in_b = rb; in_cin = rc;
      out_ready = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) begin
        q_a.push_back(ra); q_b.push_back(rb); q_c.push_back(rc);
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) begin
          chk("rnd_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = model(q_a.pop_front(), q_b.pop_front(), q_c.pop_front());
          chk_result("rnd", e);
        end
        n_out++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_timeout",     64'(cyc < 8000), 64'd1);
    chk("rnd_count_match", 64'(n_in),       64'(n_out));
    chk("rnd_queue_empty", 64'(q_a.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
